mmio_memory_map: RTL and testbench

- Parametrised dual-port address decoder that splits each port's address space into two regions.
- Below RAM_BASE: a bank of NUM_REGS MMIO registers at a fixed address stride. At or above RAM_BASE: the shared dual-port sram.
- Adds over the previous generation:
  - hardware start/busy/done flag registers with accelerator handshakes;
  - exported config bus;
  - defined write-collision priority;
  - unmapped-address error reporting.
- Sits between the host/AFU bus and the matmul, matvec and maxpool engines.

---
 rtl/mmio_map_pkg.sv | 32 +++
 rtl/mmio_decode.sv | 31 +++
 rtl/sram.sv | 26 ++
 rtl/mmio_memory_map.sv | 158 +++++++++++++++
 tb/tb_mmio_memory_map.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/mmio_map_pkg.sv
// Shared register map, flag bit positions and read-select encoding for the
// MMIO decoder and its clients.
package mmio_map_pkg;

    localparam int unsigned MATMUL_A_IN  = 0;
    localparam int unsigned MATMUL_B_IN  = 1;
    localparam int unsigned MATMUL_OUT   = 2;
    localparam int unsigned MATVEC_M_IN  = 3;
    localparam int unsigned MATVEC_V_IN  = 4;
    localparam int unsigned MATVEC_OUT   = 5;
    localparam int unsigned MP_IN        = 6;
    localparam int unsigned MP_OUT       = 7;
    localparam int unsigned MATMUL_DIM   = 8;
    localparam int unsigned MATVEC_DIM   = 9;
    localparam int unsigned MATMUL_FLAG  = 10;
    localparam int unsigned MATVEC_FLAG  = 11;
    localparam int unsigned MP_FLAG      = 12;
    localparam int unsigned BIAS_ADDR    = 13;

    localparam int unsigned FLAG_BUSY = 0;
    localparam int unsigned FLAG_DONE = 1;

    localparam logic [31:0] RAM_BASE_DEFAULT        = 32'h1000;
    localparam int unsigned REG_STRIDE_LOG2_DEFAULT = 8;

    typedef enum logic [1:0] {
        SEL_REG = 2'd0,
        SEL_RAM = 2'd1,
        SEL_ERR = 2'd2
    } rd_sel_e;

endpackage

// File: rtl/mmio_decode.sv
// Combinational per-port address classifier: register hit, sram hit or unmapped.
module mmio_decode #(
    parameter int unsigned           ADDR_WIDTH      = 32,
    parameter int unsigned           NUM_REGS        = 14,
    parameter int unsigned           IDX_W           = 4,
    parameter int unsigned           REG_STRIDE_LOG2 = 8,
    parameter logic [ADDR_WIDTH-1:0] RAM_BASE        = 32'h1000,
    parameter int unsigned           RAM_AW          = 12
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    output logic                  reg_hit,
    output logic                  ram_hit,
    output logic [IDX_W-1:0]      idx,
    output logic [RAM_AW-1:0]     ram_addr
);

    logic [ADDR_WIDTH-1:0] reg_num;
    logic [ADDR_WIDTH-1:0] ram_off;

    assign reg_num = addr >> REG_STRIDE_LOG2;
    assign ram_off = addr - RAM_BASE;

    assign reg_hit  = (addr < RAM_BASE)
                   && (addr[REG_STRIDE_LOG2-1:0] == '0)
                   && (reg_num < ADDR_WIDTH'(NUM_REGS));
    // Offsets past the window are rejected rather than truncated into it.
    assign ram_hit  = (addr >= RAM_BASE) && ((ram_off >> RAM_AW) == '0);
    assign idx      = reg_num[IDX_W-1:0];
    assign ram_addr = ram_off[RAM_AW-1:0];

endmodule

// File: rtl/sram.sv
// Dual-port synchronous sram, read-before-write on both ports, no reset.
module sram #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic [DATA_WIDTH-1:0] data_a,
    input  logic [DATA_WIDTH-1:0] data_b,
    input  logic [ADDR_WIDTH-1:0] addr_a,
    input  logic [ADDR_WIDTH-1:0] addr_b,
    input  logic                  we_a,
    input  logic                  we_b,
    output logic [DATA_WIDTH-1:0] q_a,
    output logic [DATA_WIDTH-1:0] q_b
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (we_a) mem[addr_a] <= data_a;
        if (we_b) mem[addr_b] <= data_b;
        q_a <= mem[addr_a];
        q_b <= mem[addr_b];
    end

endmodule

// File: rtl/mmio_memory_map.sv
// Dual-port MMIO decoder: register bank with engine start/busy/done flags
// below RAM_BASE, shared sram above it.
module mmio_memory_map
    import mmio_map_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH      = 32,
    parameter int unsigned           ADDR_WIDTH      = 32,
    parameter int unsigned           NUM_REGS        = 14,
    parameter int unsigned           REG_STRIDE_LOG2 = REG_STRIDE_LOG2_DEFAULT,
    parameter logic [ADDR_WIDTH-1:0] RAM_BASE        = ADDR_WIDTH'(RAM_BASE_DEFAULT),
    parameter int unsigned           RAM_AW          = 12,
    parameter int unsigned           FLAG_BASE       = MATMUL_FLAG,
    parameter int unsigned           NUM_FLAGS       = 3
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [DATA_WIDTH-1:0]            data_a,
    input  logic [DATA_WIDTH-1:0]            data_b,
    input  logic [ADDR_WIDTH-1:0]            addr_a,
    input  logic [ADDR_WIDTH-1:0]            addr_b,
    input  logic                             we_a,
    input  logic                             we_b,
    output logic signed [DATA_WIDTH-1:0]     q_a,
    output logic signed [DATA_WIDTH-1:0]     q_b,
    output logic                             err_a,
    output logic                             err_b,
    output logic [NUM_REGS*DATA_WIDTH-1:0]   cfg_o,
    output logic [NUM_FLAGS-1:0]             start_o,
    input  logic [NUM_FLAGS-1:0]             done_i
);

    localparam int unsigned IDX_W = $clog2(NUM_REGS);

    logic              reg_hit_a, reg_hit_b, ram_hit_a, ram_hit_b;
    logic [IDX_W-1:0]  idx_a, idx_b;
    logic [RAM_AW-1:0] ram_addr_a, ram_addr_b;

    logic [DATA_WIDTH-1:0] regs     [NUM_REGS];
    logic [DATA_WIDTH-1:0] regs_nxt [NUM_REGS];
    logic [DATA_WIDTH-1:0] sw_data  [NUM_REGS];
    logic [NUM_REGS-1:0]   sw_we;
    logic [NUM_FLAGS-1:0]  start_nxt;

    logic [DATA_WIDTH-1:0] reg_rd_a, reg_rd_b;
    logic [DATA_WIDTH-1:0] ram_q_a, ram_q_b;
    logic                  ram_we_a, ram_we_b;
    rd_sel_e               sel_a, sel_b;

    mmio_decode #(
        .ADDR_WIDTH(ADDR_WIDTH), .NUM_REGS(NUM_REGS), .IDX_W(IDX_W),
        .REG_STRIDE_LOG2(REG_STRIDE_LOG2), .RAM_BASE(RAM_BASE), .RAM_AW(RAM_AW)
    ) u_dec_a (
        .addr(addr_a), .reg_hit(reg_hit_a), .ram_hit(ram_hit_a),
        .idx(idx_a), .ram_addr(ram_addr_a)
    );

    mmio_decode #(
        .ADDR_WIDTH(ADDR_WIDTH), .NUM_REGS(NUM_REGS), .IDX_W(IDX_W),
        .REG_STRIDE_LOG2(REG_STRIDE_LOG2), .RAM_BASE(RAM_BASE), .RAM_AW(RAM_AW)
    ) u_dec_b (
        .addr(addr_b), .reg_hit(reg_hit_b), .ram_hit(ram_hit_b),
        .idx(idx_b), .ram_addr(ram_addr_b)
    );

    assign ram_we_a = we_a && ram_hit_a;
    assign ram_we_b = we_b && ram_hit_b && !(ram_we_a && (ram_addr_a == ram_addr_b));

    sram #(
        .DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(RAM_AW)
    ) u_sram (
        .clk(clk), .data_a(data_a), .data_b(data_b),
        .addr_a(ram_addr_a), .addr_b(ram_addr_b),
        .we_a(ram_we_a), .we_b(ram_we_b),
        .q_a(ram_q_a), .q_b(ram_q_b)
    );

    // Per-register software write, port A taking priority over port B.
    always_comb begin
        sw_we = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            sw_data[i] = '0;
            if (we_a && reg_hit_a && (idx_a == IDX_W'(i))) begin
                sw_we[i]   = 1'b1;
                sw_data[i] = data_a;
            end else if (we_b && reg_hit_b && (idx_b == IDX_W'(i))) begin
                sw_we[i]   = 1'b1;
                sw_data[i] = data_b;
            end
        end
    end

    always_comb begin
        start_nxt = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            regs_nxt[i] = sw_we[i] ? sw_data[i] : regs[i];
        end
        // Flag registers override the plain write; a software write beats done_i.
        for (int unsigned f = 0; f < NUM_FLAGS; f++) begin
            regs_nxt[FLAG_BASE+f] = regs[FLAG_BASE+f];
            if (sw_we[FLAG_BASE+f]) begin
                if (sw_data[FLAG_BASE+f][0]) begin
                    if (!regs[FLAG_BASE+f][FLAG_BUSY]) begin
                        regs_nxt[FLAG_BASE+f]            = '0;
                        regs_nxt[FLAG_BASE+f][FLAG_BUSY] = 1'b1;
                        start_nxt[f]                     = 1'b1;
                    end
                end else begin
                    regs_nxt[FLAG_BASE+f] = '0;
                end
            end else if (done_i[f] && regs[FLAG_BASE+f][FLAG_BUSY]) begin
                regs_nxt[FLAG_BASE+f]            = '0;
                regs_nxt[FLAG_BASE+f][FLAG_DONE] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) regs[i] <= '0;
            start_o  <= '0;
            reg_rd_a <= '0;
            reg_rd_b <= '0;
            sel_a    <= SEL_REG;
            sel_b    <= SEL_REG;
        end else begin
            for (int unsigned i = 0; i < NUM_REGS; i++) regs[i] <= regs_nxt[i];
            start_o  <= start_nxt;
            reg_rd_a <= reg_hit_a ? regs[idx_a] : '0;
            reg_rd_b <= reg_hit_b ? regs[idx_b] : '0;
            sel_a    <= reg_hit_a ? SEL_REG : (ram_hit_a ? SEL_RAM : SEL_ERR);
            sel_b    <= reg_hit_b ? SEL_REG : (ram_hit_b ? SEL_RAM : SEL_ERR);
        end
    end

    always_comb begin
        case (sel_a)
            SEL_REG: q_a = reg_rd_a;
            SEL_RAM: q_a = ram_q_a;
            default: q_a = '0;
        endcase
        case (sel_b)
            SEL_REG: q_b = reg_rd_b;
            SEL_RAM: q_b = ram_q_b;
            default: q_b = '0;
        endcase
    end

    assign err_a = (sel_a == SEL_ERR);
    assign err_b = (sel_b == SEL_ERR);

    always_comb begin
        cfg_o = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            cfg_o[i*DATA_WIDTH +: DATA_WIDTH] = regs[i];
        end
    end

endmodule

// File: tb/tb_mmio_memory_map.sv
// Directed scoreboard bench for mmio_memory_map: expectations are queued as each
// access is driven and compared once the one-cycle read latency has elapsed.
module tb_mmio_memory_map;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] q;
        logic        err;
        logic        chk_q;
    } port_t;

    typedef struct {
        int          port;
        logic [31:0] q;
        logic        err;
        logic        chk_q;
        string       tag;
    } exp_t;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [31:0]        data_a = '0, data_b = '0, addr_a = '0, addr_b = '0;
    logic               we_a = 1'b0, we_b = 1'b0;
    logic signed [31:0] q_a, q_b;
    logic               err_a, err_b;
    logic [14*32-1:0]   cfg_o;
    logic [2:0]         start_o;
    logic [2:0]         done_i = '0;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    mmio_memory_map #(
        .DATA_WIDTH(32), .ADDR_WIDTH(32), .NUM_REGS(14), .REG_STRIDE_LOG2(8),
        .RAM_BASE(32'h1000), .RAM_AW(12), .FLAG_BASE(10), .NUM_FLAGS(3)
    ) dut (
        .clk(clk), .rst(rst),
        .data_a(data_a), .data_b(data_b),
        .addr_a(addr_a), .addr_b(addr_b),
        .we_a(we_a), .we_b(we_b),
        .q_a(q_a), .q_b(q_b),
        .err_a(err_a), .err_b(err_b),
        .cfg_o(cfg_o), .start_o(start_o), .done_i(done_i)
    );

    always #5 clk = ~clk;

    function automatic port_t rd(input logic [31:0] addr, input logic [31:0] q,
                                 input logic err = 1'b0);
        port_t p;
        p.we = 1'b0; p.addr = addr; p.data = '0;
        p.q = q; p.err = err; p.chk_q = 1'b1;
        return p;
    endfunction

    function automatic port_t wr(input logic [31:0] addr, input logic [31:0] data,
                                 input logic [31:0] q, input logic err = 1'b0);
        port_t p;
        p.we = 1'b1; p.addr = addr; p.data = data;
        p.q = q; p.err = err; p.chk_q = 1'b1;
        return p;
    endfunction

    // Write whose read-before-write data is an unwritten sram word.
    function automatic port_t wrx(input logic [31:0] addr, input logic [31:0] data);
        port_t p;
        p.we = 1'b1; p.addr = addr; p.data = data;
        p.q = '0; p.err = 1'b0; p.chk_q = 1'b0;
        return p;
    endfunction

    function automatic port_t idle();
        return rd(32'h0, 32'h0);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input port_t a, input port_t b, input string tag);
        exp_t e;
        we_a = a.we; addr_a = a.addr; data_a = a.data;
        we_b = b.we; addr_b = b.addr; data_b = b.data;
        e.tag = tag;
        e.port = 0; e.q = a.q; e.err = a.err; e.chk_q = a.chk_q; sb.push_back(e);
        e.port = 1; e.q = b.q; e.err = b.err; e.chk_q = b.chk_q; sb.push_back(e);
        @(posedge clk);
        #1;
        while (sb.size() > 0) begin
            logic [31:0] oq;
            logic        oe;
            e  = sb.pop_front();
            oq = (e.port == 0) ? q_a : q_b;
            oe = (e.port == 0) ? err_a : err_b;
            if (e.chk_q) chk($sformatf("%s_q%s", e.tag, e.port ? "b" : "a"), oq, e.q);
            chk($sformatf("%s_err%s", e.tag, e.port ? "b" : "a"), {31'b0, oe}, {31'b0, e.err});
        end
    endtask

    task automatic chk_cfg(input string tag, input int idx, input logic [31:0] exp);
        logic [31:0] slice;
        slice = cfg_o[idx*32 +: 32];
        chk($sformatf("%s_cfg%0d", tag, idx), slice, exp);
    endtask

    initial begin
        // Reset state
        step(idle(), idle(), "rst0");
        step(idle(), idle(), "rst1");
        rst = 1'b0;
        step(idle(), idle(), "post_rst");
        chk("rst_start", {29'b0, start_o}, 32'h0);
        for (int i = 0; i < 14; i++) chk_cfg("rst", i, 32'h0);

        // Register round trip with read-before-write on the writing port
        step(wr(32'h600, 32'hDEADBEEF, 32'h0), idle(), "rt_wr");
        step(idle(), rd(32'h600, 32'hDEADBEEF), "rt_rd");
        chk_cfg("rt", 6, 32'hDEADBEEF);

        // Register collision: port A wins
        step(wr(32'h700, 32'hAAAA, 32'h0), wr(32'h700, 32'hBBBB, 32'h0), "reg_col_wr");
        step(rd(32'h700, 32'hAAAA), rd(32'h700, 32'hAAAA), "reg_col_rd");
        chk_cfg("reg_col", 7, 32'hAAAA);

        // RAM collision, top of window, and wrap-around rejection
        step(wrx(32'h1004, 32'h11), wrx(32'h1004, 32'h22), "ram_col_wr");
        step(rd(32'h1004, 32'h11), rd(32'h1004, 32'h11), "ram_col_rd");
        step(wrx(32'h1FFC, 32'h12345678), idle(), "ram_top_wr");
        step(rd(32'h1FFC, 32'h12345678), rd(32'h600, 32'hDEADBEEF), "ram_top_rd");
        step(wrx(32'h1000, 32'h77), idle(), "ram_base_wr");
        step(wr(32'h2000, 32'h99, 32'h0, 1'b1), idle(), "ram_wrap_wr");
        step(rd(32'h1000, 32'h77), rd(32'h2000, 32'h0, 1'b1), "ram_wrap_rd");
        step(idle(), idle(), "err_clear");

        // Flag handshake on the matmul flag
        step(wr(32'hA00, 32'h1, 32'h0), idle(), "flag_start");
        chk("flag_start_pulse", {29'b0, start_o}, 32'h1);
        step(rd(32'hA00, 32'h1), idle(), "flag_busy");
        chk("flag_start_once", {29'b0, start_o}, 32'h0);
        done_i = 3'b001;
        step(rd(32'hA00, 32'h1), idle(), "flag_done_cyc");
        done_i = 3'b000;
        step(rd(32'hA00, 32'h2), idle(), "flag_done");
        step(wr(32'hA00, 32'h1, 32'h2), idle(), "flag_restart");
        chk("flag_restart_pulse", {29'b0, start_o}, 32'h1);
        step(rd(32'hA00, 32'h1), idle(), "flag_rebusy");
        step(wr(32'hA00, 32'h1, 32'h1), idle(), "flag_while_busy");
        chk("flag_no_restart", {29'b0, start_o}, 32'h0);
        step(rd(32'hA00, 32'h1), idle(), "flag_still_busy");

        // Done vs. software write race on the matvec flag; stray done on idle mp flag
        step(idle(), wr(32'hB00, 32'h1, 32'h0), "race_start");
        chk("race_start_pulse", {29'b0, start_o}, 32'h2);
        done_i = 3'b110;
        step(wr(32'hB00, 32'h0, 32'h1), idle(), "race_wr");
        done_i = 3'b000;
        step(rd(32'hB00, 32'h0), rd(32'hC00, 32'h0), "race_rd");

        // Misaligned and out-of-bank register accesses
        step(wr(32'h604, 32'h55, 32'h0, 1'b1), wr(32'hE00, 32'h55, 32'h0, 1'b1), "unmap_wr");
        step(rd(32'h604, 32'h0, 1'b1), rd(32'hE00, 32'h0, 1'b1), "unmap_rd");
        step(rd(32'h600, 32'hDEADBEEF), rd(32'hD00, 32'h0), "unmap_after");
        chk_cfg("unmap", 6, 32'hDEADBEEF);
        chk_cfg("unmap", 13, 32'h0);

        // Reset mid-operation with all flags busy
        step(wr(32'hB00, 32'h1, 32'h0), wr(32'hC00, 32'h1, 32'h0), "pre_rst");
        chk("pre_rst_pulse", {29'b0, start_o}, 32'h6);
        chk_cfg("pre_rst", 10, 32'h1);
        chk_cfg("pre_rst", 11, 32'h1);
        chk_cfg("pre_rst", 12, 32'h1);
        rst    = 1'b1;
        done_i = 3'b111;
        step(wr(32'h700, 32'hFFFF, 32'h0), rd(32'h1004, 32'h0), "mid_rst");
        rst    = 1'b0;
        done_i = 3'b000;
        chk("mid_rst_start", {29'b0, start_o}, 32'h0);
        for (int i = 0; i < 14; i++) chk_cfg("mid_rst", i, 32'h0);
        step(rd(32'hA00, 32'h0), rd(32'h600, 32'h0), "post_rst_rd0");
        step(rd(32'h700, 32'h0), rd(32'h1004, 32'h11), "post_rst_rd1");
        step(rd(32'hC00, 32'h0), rd(32'hB00, 32'h0), "post_rst_rd2");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
